// File: rtl/simd_result_serializer.sv
// Vector writeback serializer: buffers SIMD result vectors and emits enabled lanes one beat at a time.
// Latency: first beat the cycle after a push into an empty FIFO; 1 beat/cycle, no bubble between vectors.
// Backpressure: wb_ready low holds the beat; in_ready is derived from the registered FIFO count only.
// Optional stall counter on perf_stall when SIMD_SER_PERF_EN is defined.

// Generic FIFO with combinational head; the caller guarantees no push when full and no pop when empty.
// Latency: a pushed entry is visible at the head on the following cycle. Backpressure: none internal.
module simd_ser_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    assign head_dat = mem[rd_ptr];
endmodule

module simd_result_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int SIMD_WIDTH = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_WIDTH  = 5,
    localparam int LW        = $clog2(SIMD_WIDTH) + 1,
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [SIMD_WIDTH*DATA_WIDTH-1:0] in_result,
    input  logic [SIMD_WIDTH-1:0]            in_zero,
    input  logic [SIMD_WIDTH-1:0]            in_overflow,
    input  logic [SIMD_WIDTH-1:0]            in_carry_out,
    input  logic [SIMD_WIDTH-1:0]            in_negative,
    input  logic [SIMD_WIDTH-1:0]            in_lane_mask,
    input  logic [TAG_WIDTH-1:0]             in_rd,
    output logic                             wb_valid,
    input  logic                             wb_ready,
    output logic [DATA_WIDTH-1:0]            wb_data,
    output logic [TAG_WIDTH-1:0]             wb_rd,
    output logic [LW-1:0]                    wb_lane,
    output logic [3:0]                       wb_flags,
    output logic                             wb_last,
    output logic [CW-1:0]                    fifo_count,
    output logic [15:0]                      perf_stall
);
    typedef struct packed {
        logic [TAG_WIDTH-1:0]             rd;
        logic [SIMD_WIDTH-1:0]            mask;
        logic [SIMD_WIDTH-1:0]            negative;
        logic [SIMD_WIDTH-1:0]            carry_out;
        logic [SIMD_WIDTH-1:0]            overflow;
        logic [SIMD_WIDTH-1:0]            zero;
        logic [SIMD_WIDTH*DATA_WIDTH-1:0] result;
    } vec_t;

    typedef enum logic {IDLE, DRAIN} state_t;

    localparam logic [SIMD_WIDTH-1:0] LANE_ONE = SIMD_WIDTH'(1);

    vec_t                  in_vec, head;
    state_t                state, state_nxt;
    logic                  push, pop, beat_done, is_last;
    logic [SIMD_WIDTH-1:0] sent_mask, rem_mask, low_bit;
    logic [LW-1:0]         lane;
    logic [DATA_WIDTH-1:0] lane_data;
    logic [TAG_WIDTH-1:0]  lane_rd;
    logic [3:0]            lane_flags;

    always_comb begin
        in_vec           = '0;
        in_vec.rd        = in_rd;
        in_vec.mask      = in_lane_mask;
        in_vec.negative  = in_negative;
        in_vec.carry_out = in_carry_out;
        in_vec.overflow  = in_overflow;
        in_vec.zero      = in_zero;
        in_vec.result    = in_result;
    end

    assign in_ready = fifo_count < CW'(FIFO_DEPTH);
    assign push     = in_valid && in_ready;

    simd_ser_fifo #(
        .W     ($bits(vec_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (in_vec),
        .pop      (pop),
        .head_dat (head),
        .count    (fifo_count)
    );

    // Remaining lanes are the head mask minus lanes already written, so a new head needs no reload.
    assign rem_mask  = head.mask & ~sent_mask;
    assign low_bit   = rem_mask & (~rem_mask + LANE_ONE);
    assign is_last   = (rem_mask & (rem_mask - LANE_ONE)) == '0;
    assign wb_valid  = (state == DRAIN) && (rem_mask != '0);
    assign beat_done = wb_valid && wb_ready;
    assign pop       = (state == DRAIN) && ((rem_mask == '0) || (beat_done && is_last));

    always_comb begin
        lane       = '0;
        lane_data  = '0;
        lane_rd    = '0;
        lane_flags = '0;
        for (int i = SIMD_WIDTH - 1; i >= 0; i--) begin
            if (rem_mask[i]) begin
                lane       = LW'(i);
                lane_data  = head.result[i*DATA_WIDTH +: DATA_WIDTH];
                lane_rd    = head.rd + TAG_WIDTH'(i);
                lane_flags = {head.negative[i], head.carry_out[i], head.overflow[i], head.zero[i]};
            end
        end
    end

    assign wb_data  = wb_valid ? lane_data  : '0;
    assign wb_rd    = wb_valid ? lane_rd    : '0;
    assign wb_lane  = wb_valid ? lane       : '0;
    assign wb_flags = wb_valid ? lane_flags : '0;
    assign wb_last  = wb_valid && is_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sent_mask <= '0;
        end else begin
            state <= state_nxt;
            if (pop)            sent_mask <= '0;
            else if (beat_done) sent_mask <= sent_mask | low_bit;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (push) state_nxt = DRAIN;
            DRAIN:   if (pop && !push && fifo_count == CW'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef SIMD_SER_PERF_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (wb_valid && !wb_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign perf_stall = stall_cnt;
`else
    assign perf_stall = '0;
`endif
endmodule

// File: tb/tb_simd_result_serializer.sv
// Randomized and directed checks of simd_result_serializer against a lane-list reference model.
module tb_simd_result_serializer;
    localparam int DW = 32, SW = 4, FD = 4, TW = 5;
    localparam int LW = $clog2(SW) + 1, CW = $clog2(FD) + 1;
`ifdef SIMD_SER_PERF_EN
    localparam int PERF_EXP = 10;
`else
    localparam int PERF_EXP = 0;
`endif

    logic clk = 0, rst_n = 0;
    logic in_valid = 0, in_ready;
    logic [SW*DW-1:0] in_result = '0;
    logic [SW-1:0] in_zero = '0, in_overflow = '0, in_carry_out = '0, in_negative = '0, in_lane_mask = '0;
    logic [TW-1:0] in_rd = '0;
    logic wb_valid, wb_ready = 0, wb_last;
    logic [DW-1:0] wb_data;
    logic [TW-1:0] wb_rd;
    logic [LW-1:0] wb_lane;
    logic [3:0] wb_flags;
    logic [CW-1:0] fifo_count;
    logic [15:0] perf_stall;

    simd_result_serializer #(.DATA_WIDTH(DW), .SIMD_WIDTH(SW), .FIFO_DEPTH(FD), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_zero(in_zero), .in_overflow(in_overflow), .in_carry_out(in_carry_out),
        .in_negative(in_negative), .in_lane_mask(in_lane_mask), .in_rd(in_rd),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_lane(wb_lane), .wb_flags(wb_flags), .wb_last(wb_last), .fifo_count(fifo_count),
        .perf_stall(perf_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] rd;
        int            lane;
        logic [3:0]    flags;
        bit            last;
    } beat_t;

    beat_t sbq[$];
    int n_cmp = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Reference: each enabled lane becomes one beat in ascending lane order; the highest enabled lane is last.
    task automatic model_push(input logic [SW-1:0] m, input logic [TW-1:0] rd, input logic [SW*DW-1:0] res,
                              input logic [SW-1:0] z, input logic [SW-1:0] o, input logic [SW-1:0] c,
                              input logic [SW-1:0] n);
        int last_i = -1;
        for (int i = 0; i < SW; i++) if (m[i]) last_i = i;
        for (int i = 0; i < SW; i++) begin
            if (m[i]) begin
                beat_t b;
                b.data  = res[i*DW +: DW];
                b.rd    = TW'((int'(rd) + i) % (1 << TW));
                b.lane  = i;
                b.flags = {n[i], c[i], o[i], z[i]};
                b.last  = (i == last_i);
                sbq.push_back(b);
            end
        end
    endtask

    // Called a little after a rising edge; returns #1 after the accepting edge.
    task automatic push_vec(input logic [SW-1:0] m, input logic [TW-1:0] rd, input logic [SW*DW-1:0] res);
        int w = 0;
        in_lane_mask = m; in_rd = rd; in_result = res;
        in_zero = SW'($urandom); in_overflow = SW'($urandom);
        in_carry_out = SW'($urandom); in_negative = SW'($urandom);
        in_valid = 1;
        while (!in_ready && w < 200) begin @(posedge clk); #1; w++; end
        if (!in_ready) begin
            chk("push_timeout", 64'(in_ready), 64'd1);
            in_valid = 0;
            return;
        end
        @(posedge clk);
        model_push(m, rd, res, in_zero, in_overflow, in_carry_out, in_negative);
        #1 in_valid = 0;
    endtask

    function automatic logic [SW*DW-1:0] rand_res();
        logic [SW*DW-1:0] r;
        for (int i = 0; i < SW; i++) r[i*DW +: DW] = $urandom;
        return r;
    endfunction

    task automatic wait_drain();
        int w = 0;
        while ((fifo_count != 0 || sbq.size() != 0) && w < 500) begin @(posedge clk); #1; w++; end
        chk("drain_timeout", 64'(w < 500), 64'd1);
    endtask

    // Monitor: scoreboard compare on each accepted beat; held beats must not change while stalled.
    initial begin
        logic pv_stall = 0;
        logic [63:0] pv_vec = '0, cur_vec;
        beat_t b;
        forever begin
            @(negedge clk);
            cur_vec = 64'({wb_valid, wb_data, wb_rd, wb_lane, wb_flags, wb_last});
            if (rst_n) begin
                if (pv_stall) chk("hold", cur_vec, pv_vec);
                if (wb_valid && wb_ready) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_beat", cur_vec, 64'd0);
                    end else begin
                        b = sbq.pop_front();
                        chk("beat", 64'({wb_data, wb_rd, wb_lane, wb_flags, wb_last}),
                            64'({b.data, b.rd, LW'(b.lane), b.flags, b.last}));
                    end
                end
                pv_stall = wb_valid && !wb_ready;
                pv_vec   = cur_vec;
            end else begin
                pv_stall = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_outputs", 64'({wb_data, wb_rd, wb_lane, wb_flags, wb_last}), 64'd0);
        chk("rst_perf", 64'(perf_stall), 64'd0);
        rst_n = 1;
        @(posedge clk); #1;

        // Full mask, lanes on consecutive cycles starting the cycle after the push
        wb_ready = 1;
        push_vec(4'b1111, 5'd8, {32'd4, 32'd3, 32'd2, 32'd1});
        for (int k = 0; k < 4; k++) begin
            #3 chk("t1_valid", 64'(wb_valid), 64'd1);
            @(posedge clk); #1;
        end
        #3 chk("t1_idle", 64'(wb_valid), 64'd0);
        wait_drain();

        // Sparse mask with register wrap, then an all-zero mask
        push_vec(4'b1010, 5'd31, rand_res());
        wait_drain();
        push_vec(4'b0000, 5'd3, rand_res());
        #3 chk("t2_zero_count1", 64'(fifo_count), 64'd1);
        chk("t2_zero_novalid", 64'(wb_valid), 64'd0);
        @(posedge clk); #3;
        chk("t2_zero_count0", 64'(fifo_count), 64'd0);
        @(posedge clk); #1;

        // Fill under backpressure; further pushes refused until space frees
        wb_ready = 0;
        for (int k = 0; k < 4; k++) push_vec(4'b1111, TW'($urandom), rand_res());
        #3 chk("t3_full_ready", 64'(in_ready), 64'd0);
        chk("t3_full_count", 64'(fifo_count), 64'd4);
        in_valid = 1;
        repeat (3) @(posedge clk);
        #1 chk("t3_refused_count", 64'(fifo_count), 64'd4);
        in_valid = 0;
        wb_ready = 1;
        push_vec(4'b1111, TW'($urandom), rand_res());
        wait_drain();

        // Back-to-back single-lane vectors: steady one beat per cycle, count constant
        for (int k = 0; k < 6; k++) begin
            push_vec(4'b0001, TW'($urandom), rand_res());
            #3 chk("t4_valid", 64'(wb_valid), 64'd1);
            chk("t4_count", 64'(fifo_count), 64'd1);
        end
        wait_drain();

        // Reset in the middle of a vector
        push_vec(4'b1111, TW'($urandom), rand_res());
        @(posedge clk); @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("t5_valid", 64'(wb_valid), 64'd0);
        chk("t5_in_ready", 64'(in_ready), 64'd1);
        chk("t5_count", 64'(fifo_count), 64'd0);
        chk("t5_outputs", 64'({wb_data, wb_rd, wb_lane, wb_flags, wb_last}), 64'd0);
        sbq.delete();
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
        push_vec(4'b1111, TW'($urandom), rand_res());
        wait_drain();
        chk("t5_perf_clear", 64'(perf_stall), 64'd0);

        // Ten stall cycles
        wb_ready = 0;
        push_vec(4'b0001, TW'($urandom), rand_res());
        repeat (10) @(posedge clk);
        #1 chk("t6_perf", 64'(perf_stall), 64'(PERF_EXP));
        wb_ready = 1;
        wait_drain();
        chk("t6_perf_after", 64'(perf_stall), 64'(PERF_EXP));

        // Random traffic with random backpressure
        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    push_vec(SW'($urandom), TW'($urandom), rand_res());
                end
                done = 1;
            end
            begin
                while (!done) begin
                    wb_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
            end
        join
        wb_ready = 1;
        wait_drain();
        chk("sb_empty", 64'(sbq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
